sw_alloc_rr_lock_4port: RTL and testbench
=========================================

Name: sw_alloc_rr_lock_4port

Overview:
- Switch allocator for the 4-port mesh router. Ports are X1, X2, Y and LOCAL.
- Shares each output port among the four input pipelines using per-output round-robin arbitration.
- Holds an output for multi-flit packets (wormhole lock) and respects downstream full.
- Drives the per-input pipeline advance enables and the registered output mux selects used by the router's output registers.

Parameters:
- LOCK_TIMEOUT, 16: idle cycles a locked output waits for its owner before forced release. Range 2..255.
- TO_W, 8: width of the per-output timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global allocation enable
- req_valid  in  4  per-input head flit valid; bit i: 0=X1, 1=X2, 2=Y, 3=LOCAL
- req_port  in  12  per-input destination port code, input i at [3i+2:3i]
- req_last  in  4  flit is last of its packet (single-flit packets drive 1)
- out_full  in  4  downstream full per output, same index order (LOCAL is normally tied 0)
- grant  out  4  combinational; input i advances/pops this cycle
- out_sel  out  12  registered; output o mux select at [3o+2:3o], SW code of the source input
- out_lock  out  4  registered; output o is locked to a packet owner
- timeout_pulse  out  4  registered; one-cycle pulse on forced lock release of output o

Behaviour:
- Codes (SW_*): X1=3'd0, X2=3'd1, Y1=3'd2, LOCAL=3'd3, STOP=3'd7. req_port values 4..7 are ignored: that input gets no grant.
- State per output o:
  - ptr[o], 2b, round-robin start
  - lock[o], 1b
  - owner[o], 2b
  - tocnt[o], TO_W bits
- Reset values: out_sel=12'hFFF (all STOP), out_lock=0, timeout_pulse=0, ptr=0, lock=0, owner=0, tocnt=0. grant=0 while rst_n=0.
- Eligibility (combinational): input i is eligible for output o iff all of the following hold:
  - en=1
  - req_valid[i]=1
  - req_port[i]==o
  - out_full[o]=0
  - lock[o]=0, or owner[o]==i
- Arbitration:
  - Each output picks the first eligible input scanning ptr[o], ptr[o]+1, … mod 4.
  - grant[i]=1 iff input i is picked by its requested output.
  - Each input requests exactly one output, so at most one grant per input.
- Latency:
  - grant is in the same cycle as the request.
  - out_sel[o] updates at the next rising edge to the code of the granted input, or STOP if none. This aligns with the router's one-stage output register.
- Pointer: on a grant to input i with req_last=1, ptr[o] <= i+1 mod 4. No ptr change on non-last grants or when there is no grant.
- Lock rules:
  - A grant with req_last=0 while unlocked sets lock[o]=1 and owner[o]=i.
  - A grant with req_last=1 clears lock[o].
  - out_lock mirrors lock.
- Timeout:
  - While lock[o]=1, en=1 and output o has no grant, tocnt[o] increments. Any grant on o clears tocnt[o].
  - When tocnt[o] reaches LOCK_TIMEOUT-1 and the cycle is again idle:
    - lock[o] <= 0, tocnt[o] <= 0
    - ptr[o] <= owner[o]+1
    - timeout_pulse[o] <= 1 for exactly one cycle
  - Other inputs become eligible in the following cycle.
- out_full held:
  - Cycles where output o is blocked by out_full[o] count as idle for the timeout only if the owner is not requesting.
  - If the owner requests but out_full=1, tocnt holds.
- en=0: all grants 0; out_sel <= all STOP; ptr, lock, owner and tocnt hold; timeout_pulse <= 0.
- Simultaneous events: a last-flit grant and a timeout expiry cannot coincide, because a grant clears tocnt. Grant wins.
- Reset mid-packet: all locks drop immediately (asynchronous). Requesters are expected to be reset by the same rst_n.

Decomposition:
- Shared include (global defines): SW_X1/SW_X2/SW_Y1/SW_LOCAL/SW_STOP codes and port indices.
- Sub-module rr_arb4:
  - 4-bit request, 2-bit ptr → one-hot grant + 2-bit index + any.
  - Purely combinational, instantiated once per output.
- Lock, pointer and timeout state live in the top module, in a generate loop over outputs.

Test Plan:
1. Reset: hold rst_n=0 with random requests → grant=0, out_sel=12'hFFF, out_lock=0; after release with no requests, out_sel stays 12'hFFF.
2. Round-robin: X1, X2, Y all req_port=3 (LOCAL), last=1; each drops its request the cycle after its grant → grants in order X1, X2, Y. out_sel[11:9] reads 0, 1, 2 one cycle after each grant; ptr ends at 3.
3. Backpressure: LOCAL requests port 0 with out_full[0]=1 for 3 cycles → grant=0 and out_sel[2:0]=7. Deassert full → grant[3]=1 that cycle, out_sel[2:0]=3 next cycle.
4. Wormhole lock: X2 sends a 3-flit packet to Y (last=0,0,1) while LOCAL continuously requests Y → LOCAL is never granted during the packet and out_lock[2]=1. LOCAL is granted the cycle after X2's last flit; out_lock[2]=0 after the last flit.
5. Timeout: LOCK_TIMEOUT=4; X1 sends a non-last flit to X2, then drops req_valid; Y requests X2 → timeout_pulse[1]=1 for one cycle after 4 idle cycles. Y is granted the next cycle.
6. Enable: en=0 mid-lock for 10 cycles (LOCK_TIMEOUT=4) → no grants, out_sel=12'hFFF, no timeout. With en=1 restored, the owner resumes and is granted first.

Source files
------------

// File: rtl/sw_alloc_rr_lock_4port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_alloc_rr_lock_4port_pkg
// Description : Switch codes and port indices shared by the switch allocator.
// Revision    : 1.0
// ============================================================================
package sw_alloc_rr_lock_4port_pkg;

    localparam int unsigned NUM_PORTS = 4;

    localparam int unsigned PORT_X1    = 0;
    localparam int unsigned PORT_X2    = 1;
    localparam int unsigned PORT_Y     = 2;
    localparam int unsigned PORT_LOCAL = 3;

    localparam logic [2:0] SW_X1    = 3'd0;
    localparam logic [2:0] SW_X2    = 3'd1;
    localparam logic [2:0] SW_Y1    = 3'd2;
    localparam logic [2:0] SW_LOCAL = 3'd3;
    localparam logic [2:0] SW_STOP  = 3'd7;

    // Input index to output mux select code.
    function automatic logic [2:0] sw_code(input logic [1:0] idx);
        logic [2:0] code;
        case (idx)
            2'd0:    code = SW_X1;
            2'd1:    code = SW_X2;
            2'd2:    code = SW_Y1;
            default: code = SW_LOCAL;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_alloc_rr_lock_4port_rr_arb4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4
// Description : Combinational 4-way round-robin pick starting at ptr.
// Revision    : 1.0
// ============================================================================
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] w_cand;

    always_comb begin
        gnt    = '0;
        idx    = ptr;
        any    = 1'b0;
        w_cand = ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = ptr + 2'(k);
            if (!any && req[w_cand]) begin
                any         = 1'b1;
                idx         = w_cand;
                gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_alloc_rr_lock_4port.sv
`default_nettype none
// ============================================================================
// Module      : sw_alloc_rr_lock_4port
// Description : Per-output round-robin switch allocator with wormhole lock,
//               downstream backpressure and lock timeout release.
// Revision    : 1.0
// ============================================================================
module sw_alloc_rr_lock_4port
    import sw_alloc_rr_lock_4port_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 16,
    parameter int unsigned TO_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  req_valid,
    input  logic [11:0] req_port,
    input  logic [3:0]  req_last,
    input  logic [3:0]  out_full,
    output logic [3:0]  grant,
    output logic [11:0] out_sel,
    output logic [3:0]  out_lock,
    output logic [3:0]  timeout_pulse
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(LOCK_TIMEOUT - 1);

    logic [3:0][2:0] w_dst;
    logic [3:0][3:0] w_gnt;
    logic [3:0]      w_grant;

    genvar gi, go;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_dst
            assign w_dst[gi] = req_port[3*gi +: 3];
        end
    endgenerate

    generate
        for (go = 0; go < NUM_PORTS; go++) begin : g_out
            logic [3:0]      w_elig;
            logic [1:0]      w_idx;
            logic            w_any;
            logic            w_own_req;
            logic            w_idle;
            logic [1:0]      r_ptr;
            logic [1:0]      r_owner;
            logic            r_lock;
            logic [TO_W-1:0] r_tocnt;
            logic [2:0]      r_sel;
            logic            r_pulse;

            for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
                assign w_elig[gi] = en & req_valid[gi] & (w_dst[gi] == 3'(go)) &
                                    ~out_full[go] & (~r_lock | (r_owner == 2'(gi)));
            end

            rr_arb4 u_arb (
                .req (w_elig),
                .ptr (r_ptr),
                .gnt (w_gnt[go]),
                .idx (w_idx),
                .any (w_any)
            );

            // An owner stalled only by downstream full is not abandoning its lock.
            assign w_own_req = req_valid[r_owner] & (w_dst[r_owner] == 3'(go));
            assign w_idle    = r_lock & ~w_any & ~(w_own_req & out_full[go]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr   <= 2'd0;
                    r_owner <= 2'd0;
                    r_lock  <= 1'b0;
                    r_tocnt <= '0;
                    r_sel   <= SW_STOP;
                    r_pulse <= 1'b0;
                end else if (!en) begin
                    r_sel   <= SW_STOP;
                    r_pulse <= 1'b0;
                end else if (w_any) begin
                    r_sel   <= sw_code(w_idx);
                    r_tocnt <= '0;
                    r_pulse <= 1'b0;
                    if (req_last[w_idx]) begin
                        r_lock <= 1'b0;
                        r_ptr  <= w_idx + 2'd1;
                    end else if (!r_lock) begin
                        r_lock  <= 1'b1;
                        r_owner <= w_idx;
                    end
                end else begin
                    r_sel   <= SW_STOP;
                    r_pulse <= 1'b0;
                    if (w_idle) begin
                        if (r_tocnt == c_to_last) begin
                            r_lock  <= 1'b0;
                            r_tocnt <= '0;
                            r_ptr   <= r_owner + 2'd1;
                            r_pulse <= 1'b1;
                        end else begin
                            r_tocnt <= r_tocnt + 1'b1;
                        end
                    end
                end
            end

            assign out_sel[3*go +: 3] = r_sel;
            assign out_lock[go]       = r_lock;
            assign timeout_pulse[go]  = r_pulse;
        end
    endgenerate

    always_comb begin
        w_grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_grant = w_grant | w_gnt[o];
        end
    end

    assign grant = rst_n ? w_grant : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_sw_alloc_rr_lock_4port.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_alloc_rr_lock_4port
// Description : Directed-vector scoreboard bench for the switch allocator.
// Revision    : 1.0
// ============================================================================
module tb_sw_alloc_rr_lock_4port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_port = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  out_full = '0;
    logic [3:0]  grant;
    logic [11:0] out_sel;
    logic [3:0]  out_lock;
    logic [3:0]  timeout_pulse;

    typedef struct packed {
        logic [3:0]  g;
        logic [11:0] s;
        logic [3:0]  lk;
        logic [3:0]  pu;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    sw_alloc_rr_lock_4port #(
        .LOCK_TIMEOUT (4),
        .TO_W         (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_port      (req_port),
        .req_last      (req_last),
        .out_full      (out_full),
        .grant         (grant),
        .out_sel       (out_sel),
        .out_lock      (out_lock),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pp(input logic [2:0] p3, p2, p1, p0);
        return {p3, p2, p1, p0};
    endfunction

    // Apply one input vector just after the edge; expected registered values
    // are the result of the previous vector.
    task automatic step(input logic r, input logic e, input logic [3:0] v,
                        input logic [11:0] p, input logic [3:0] l, input logic [3:0] f,
                        input logic [3:0] g, input logic [11:0] s,
                        input logic [3:0] lk, input logic [3:0] pu);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = r;
        en        = e;
        req_valid = v;
        req_port  = p;
        req_last  = l;
        out_full  = f;
        x.g = g; x.s = s; x.lk = lk; x.pu = pu;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            n_vec++;
            if (grant !== x.g) begin
                n_bad++;
                $display("FAIL grant: got %b expected %b at %0t", grant, x.g, $time);
            end
            n_vec++;
            if (out_sel !== x.s) begin
                n_bad++;
                $display("FAIL out_sel: got %h expected %h at %0t", out_sel, x.s, $time);
            end
            n_vec++;
            if (out_lock !== x.lk) begin
                n_bad++;
                $display("FAIL out_lock: got %b expected %b at %0t", out_lock, x.lk, $time);
            end
            n_vec++;
            if (timeout_pulse !== x.pu) begin
                n_bad++;
                $display("FAIL timeout_pulse: got %b expected %b at %0t", timeout_pulse, x.pu, $time);
            end
        end
    end

    initial begin
        // Reset with all inputs requesting
        for (int k = 0; k < 3; k++)
            step(0, 1, 4'b1111, pp(3'd0, 3'd1, 3'd2, 3'd3), 4'b1111, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd0, 3'd0, 3'd0, 3'd0), 4'b0000, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd0, 3'd0, 3'd0, 3'd0), 4'b0000, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);

        // Round-robin on LOCAL output
        step(1, 1, 4'b0111, pp(3'd0, 3'd3, 3'd3, 3'd3), 4'b1111, 4'b0000, 4'b0001, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0110, pp(3'd0, 3'd3, 3'd3, 3'd3), 4'b1111, 4'b0000, 4'b0010, 12'h1FF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd0, 3'd3, 3'd3, 3'd3), 4'b1111, 4'b0000, 4'b0100, 12'h3FF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd0, 3'd3, 3'd3, 3'd3), 4'b1111, 4'b0000, 4'b0000, 12'h5FF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd0, 3'd3, 3'd3, 3'd3), 4'b1111, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b1001, pp(3'd3, 3'd0, 3'd0, 3'd3), 4'b1111, 4'b0000, 4'b1000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd3, 3'd0, 3'd0, 3'd3), 4'b1111, 4'b0000, 4'b0000, 12'h7FF, 4'b0000, 4'b0000);

        // Backpressure on X1 output
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1000, pp(3'd0, 3'd7, 3'd7, 3'd7), 4'b1111, 4'b0001, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b1000, pp(3'd0, 3'd7, 3'd7, 3'd7), 4'b1111, 4'b0000, 4'b1000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd0, 3'd7, 3'd7, 3'd7), 4'b1111, 4'b0000, 4'b0000, 12'hFFB, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd0, 3'd7, 3'd7, 3'd7), 4'b1111, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);

        // Wormhole: X2 three-flit packet to Y while LOCAL competes
        step(1, 1, 4'b1010, pp(3'd2, 3'd7, 3'd2, 3'd7), 4'b1000, 4'b0000, 4'b0010, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b1010, pp(3'd2, 3'd7, 3'd2, 3'd7), 4'b1000, 4'b0000, 4'b0010, 12'hE7F, 4'b0100, 4'b0000);
        step(1, 1, 4'b1010, pp(3'd2, 3'd7, 3'd2, 3'd7), 4'b1010, 4'b0000, 4'b0010, 12'hE7F, 4'b0100, 4'b0000);
        step(1, 1, 4'b1000, pp(3'd2, 3'd7, 3'd2, 3'd7), 4'b1010, 4'b0000, 4'b1000, 12'hE7F, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd2, 3'd7, 3'd2, 3'd7), 4'b1010, 4'b0000, 4'b0000, 12'hEFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd2, 3'd7, 3'd2, 3'd7), 4'b1010, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);

        // Timeout: X1 locks X2 output then vanishes; Y waits
        step(1, 1, 4'b0001, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0001, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFC7, 4'b0010, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFFF, 4'b0010, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFFF, 4'b0010, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFFF, 4'b0010, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0100, 12'hFFF, 4'b0000, 4'b0010);
        step(1, 1, 4'b0000, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFD7, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);

        // Enable dropped mid-lock longer than the timeout
        step(1, 1, 4'b0001, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0000, 4'b0000, 4'b0001, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 0, 4'b0101, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFC7, 4'b0010, 4'b0000);
        for (int k = 0; k < 9; k++)
            step(1, 0, 4'b0101, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0000, 12'hFFF, 4'b0010, 4'b0000);
        step(1, 1, 4'b0101, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0100, 4'b0000, 4'b0001, 12'hFFF, 4'b0010, 4'b0000);
        step(1, 1, 4'b0101, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0101, 4'b0000, 4'b0001, 12'hFC7, 4'b0010, 4'b0000);
        step(1, 1, 4'b0100, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0101, 4'b0000, 4'b0100, 12'hFC7, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd7, 3'd1, 3'd7, 3'd1), 4'b0101, 4'b0000, 4'b0000, 12'hFD7, 4'b0000, 4'b0000);

        // Unused destination code is never granted
        step(1, 1, 4'b0001, pp(3'd7, 3'd7, 3'd7, 3'd5), 4'b0001, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);
        step(1, 1, 4'b0000, pp(3'd7, 3'd7, 3'd7, 3'd5), 4'b0001, 4'b0000, 4'b0000, 12'hFFF, 4'b0000, 4'b0000);

        begin
            int waited;
            waited = 0;
            while (q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            if (q.size() > 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain: got %0d pending expected 0", q.size());
            end
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
